// File: rtl/auth_pkg.sv
// Shared types and command bytes for the BLE authorisation receiver.
package auth_pkg;

    typedef enum logic [1:0] {
        OFF,
        PWR1,
        PWR2
    } auth_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_STOP = 8'h53;

endpackage

// File: rtl/auth_rx_if.sv
// Received-byte stream from the UART core to the authorisation logic.
interface auth_rx_if;

    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       frm_err;

    modport master (output rx_rdy, output rx_data, output frm_err);
    modport slave  (input  rx_rdy, input  rx_data, input  frm_err);

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronised input, half-bit start qualification,
// mid-bit sampling of data and stop, one-cycle rx_rdy / frm_err strobes.
module uart_rx_core
    import auth_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rx,
    auth_rx_if.master    o_bus
);

    localparam int               CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);

    uart_state_t      r_state, w_state_nxt;
    logic             r_sync1, r_sync2, r_rx_prev;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_rdy, w_rdy_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             w_fall;
    logic             w_tick;

    // Idle-high reset value keeps a reset release from looking like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop takes the previous stage's old value.
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;
    // Sampling happens as the counter passes 1, giving exactly N cycles per load of N.
    assign w_tick = (r_cnt == CNT_W'(1));

    always_comb begin
        // NOTE: every next-state value gets a default first, so no latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_rdy_nxt     = 1'b0;
        w_ferr_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt   = DATA;
                    w_cnt_nxt     = CNT_FULL;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nxt   = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt     = CNT_FULL;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    if (r_sync2) begin
                        w_data_nxt = r_shift;
                        w_rdy_nxt  = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_rdy     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_rdy     <= w_rdy_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    assign o_bus.rx_rdy  = r_rdy;
    assign o_bus.rx_data = r_data;
    assign o_bus.frm_err = r_ferr;

endmodule

// File: rtl/auth_rx.sv
// BLE power authorisation: 'G' powers up, 'S' or rider leaving powers down.
// Optional idle power-down when AUTH_IDLE_TIMEOUT_EN is defined.
module auth_rx
    import auth_pkg::*;
#(
    parameter int BAUD_DIV    = 2604
`ifdef AUTH_IDLE_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 2**26
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       frm_err
);

    auth_rx_if u_bus ();

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .i_rx  (RX),
        .o_bus (u_bus)
    );

    auth_state_t r_auth, w_auth_nxt;
    logic        r_pwr_up;
    logic        w_go, w_stop;
    logic        w_timeout;

    assign w_go   = u_bus.rx_rdy && (u_bus.rx_data == CMD_GO);
    assign w_stop = u_bus.rx_rdy && (u_bus.rx_data == CMD_STOP);

`ifdef AUTH_IDLE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_idle_cnt;

    assign w_timeout = (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!(r_pwr_up && rider_off) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_auth_nxt = r_auth;
        case (r_auth)
            OFF:  if (w_go) w_auth_nxt = PWR1;
            PWR1: if (w_stop) w_auth_nxt = rider_off ? OFF : PWR2;
            // A fresh 'G' cancels a pending shutdown even if the rider just left.
            PWR2: begin
                if (w_go) begin
                    w_auth_nxt = PWR1;
                end else if (rider_off) begin
                    w_auth_nxt = OFF;
                end
            end
            default: w_auth_nxt = OFF;
        endcase
        if (w_timeout) begin
            w_auth_nxt = OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_auth   <= OFF;
            r_pwr_up <= 1'b0;
        end else begin
            r_auth   <= w_auth_nxt;
            r_pwr_up <= (w_auth_nxt != OFF);
        end
    end

    assign pwr_up  = r_pwr_up;
    assign rx_rdy  = u_bus.rx_rdy;
    assign rx_data = u_bus.rx_data;
    assign frm_err = u_bus.frm_err;

endmodule

// File: doc/auth_rx.md
AUTH_RX -- requirements
Module: auth_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz, 19200 baud).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2^26, rider-off idle cycles before auto power-down (AUTH_IDLE_TIMEOUT_EN only).
REQ-003 SHALL have port clk  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port RX  input  1  asynchronous UART serial input from the BLE module, idle high.
REQ-006 SHALL have port rider_off  input  1  level from steering/load-cell logic, high when no rider is present.
REQ-007 SHALL have port pwr_up  output  1  registered power-enable to balance control and steering.
REQ-008 SHALL have port rx_rdy  output  1  one-cycle strobe, valid byte received.
REQ-009 SHALL have port rx_data  output  8  last valid byte, held until the next valid byte.
REQ-010 SHALL have port frm_err  output  1  one-cycle strobe, stop bit sampled low.

Function
REQ-011 SHALL pass RX through a two-flop synchronizer; both flops SHALL hold 1 while rst is high.
REQ-012 UART FSM SHALL use states IDLE, START, DATA, STOP.
REQ-013 In IDLE, a synchronized falling edge SHALL enter START and load the baud counter with BAUD_DIV/2.
REQ-014 START SHALL sample at counter expiry; sample 1 -> IDLE (glitch, no strobe); sample 0 -> DATA with counter = BAUD_DIV.
REQ-015 DATA SHALL take 8 samples at BAUD_DIV spacing, LSB first, into a shift register, then enter STOP.
REQ-016 STOP sample 1 SHALL load rx_data and pulse rx_rdy in the next cycle.
REQ-017 STOP sample 0 SHALL pulse frm_err, leave rx_data unchanged, and not pulse rx_rdy.
REQ-018 After a STOP sample the FSM SHALL return to IDLE; a new falling edge in the cycle after rx_rdy or frm_err SHALL be accepted.
REQ-019 Auth FSM SHALL use states OFF, PWR1 (powered, no shutdown pending) and PWR2 (shutdown pending). pwr_up SHALL be 1 in PWR1 and PWR2.
REQ-020 OFF SHALL go to PWR1 on rx_rdy with rx_data 8'h47 ('G').
REQ-021 PWR1 SHALL act on rx_rdy with 8'h53 ('S'): rider_off=1 in that cycle -> OFF; rider_off=0 -> PWR2.
REQ-022 PWR2 SHALL go to OFF when rider_off=1, and to PWR1 on 'G'; 'G' and rider_off in the same cycle -> PWR1.
REQ-023 Bytes other than 'G'/'S', and 'G' while in PWR1, SHALL cause no auth state change.
REQ-024 pwr_up SHALL change in the cycle after the qualifying rx_rdy (or rider_off edge in PWR2). Total latency from stop-bit sample to pwr_up is 2 cycles.

Reset
REQ-025 rst SHALL force UART FSM=IDLE, auth FSM=OFF, pwr_up=0, rx_rdy=0, frm_err=0, rx_data=8'h00, counters=0 on the next clk edge.
REQ-026 rst mid-frame SHALL discard the partial byte; the next strobe SHALL come only from a full new frame.

Configuration
REQ-027 Macro AUTH_IDLE_TIMEOUT_EN defined: a counter SHALL count while pwr_up=1 and rider_off=1, clear when either is 0, and force OFF when it reaches TIMEOUT_CYC-1. This happens in any powered state, without 'S'.
REQ-028 Macro undefined: the timeout counter SHALL be absent, and power-down SHALL occur only per REQ-021/022.

Structure
REQ-029 Package auth_pkg SHALL hold the auth state enum, the UART state enum, CMD_GO=8'h47 and CMD_STOP=8'h53.
REQ-030 The UART receiver (REQ-011..018) SHALL be sub-module uart_rx_core. The auth FSM and timeout SHALL live in auth_rx.

Verification
REQ-031 Send 'G' (8'h47) after reset -> rx_rdy one pulse, rx_data=8'h47, pwr_up=1 two cycles after the stop-bit sample.
REQ-032 Powered, rider_off=0, send 'S' -> pwr_up stays 1 (PWR2); then rider_off=1 -> pwr_up=0 the next cycle.
REQ-033 Powered, rider_off=1, send 'S' -> pwr_up=0; then send 8'h41 -> rx_rdy pulses, pwr_up stays 0.
REQ-034 Frame 8'h47 with stop bit 0 -> frm_err pulse, no rx_rdy, pwr_up stays 0. RX low glitch of 100 cycles -> no strobe.
REQ-035 Assert rst during bit 4 of 'G', then send a full 'G' -> exactly one rx_rdy, rx_data=8'h47, pwr_up=1.
REQ-036 AUTH_IDLE_TIMEOUT_EN defined, TIMEOUT_CYC=1000, powered, rider_off=1 -> pwr_up=0 after 1000 cycles. A rider_off=0 pulse at cycle 500 restarts the count.
